// File: rtl/logic16_arbiter_pkg.sv
// Shared types for the logic16 arbiter: op codes, FSM states
// and the round-robin pointer increment.
package logic16_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

    localparam int ID_W = 3;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/logic16_unit.sv
// Combinational bitwise logic unit; every function is composed
// purely from two-input NAND terms.
module logic16_unit
    import logic16_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out
);

    function automatic logic [WIDTH-1:0] nd(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        return ~(x & y);
    endfunction

    logic [WIDTH-1:0] na;
    logic [WIDTH-1:0] nb;
    logic [WIDTH-1:0] nab;
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;

    assign na    = nd(a, a);
    assign nb    = nd(b, b);
    assign nab   = nd(a, b);
    assign and_r = nd(nab, nab);
    assign or_r  = nd(na, nb);
    // Classic four-NAND XOR sharing the a-NAND-b term
    assign xor_r = nd(nd(a, nab), nd(b, nab));

    always_comb begin
        out = '0;
        unique case (op_e'(op))
            OP_AND: out = and_r;
            OP_OR:  out = or_r;
            OP_XOR: out = xor_r;
            OP_NOT: out = na;
        endcase
    end

endmodule

// File: rtl/logic16_arbiter.sv
// Round-robin front end that shares one logic16_unit among
// NUM_REQ requesters, one operation in flight at a time.
module logic16_arbiter
    import logic16_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e           state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    gnt;
    logic [PW-1:0]    gnt_q;
    logic             found;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] unit_out;

    // First valid requester at or after rr_ptr, wrapping
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = PW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && found && !reset) begin
            req_ready[gnt] = 1'b1;
        end
    end

    assign busy = (state != S_IDLE);

    logic16_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .out (unit_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            gnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt_q <= gnt;
                        op_q  <= req_op[2*int'(gnt) +: 2];
                        a_q   <= req_a[WIDTH*int'(gnt) +: WIDTH];
                        b_q   <= req_b[WIDTH*int'(gnt) +: WIDTH];
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data  <= unit_out;
                    rsp_id    <= ID_W'(gnt_q);
                    rsp_valid <= 1'b1;
                    rr_ptr    <= PW'(wrap_inc(int'(gnt_q), NUM_REQ));
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic16_arbiter.sv
// Scoreboard bench for logic16_arbiter: directed requests push
// expected grants and responses, a negedge monitor checks them.
module tb_logic16_arbiter;
    import logic16_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           busy;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]  id;
        logic [15:0] data;
    } rsp_t;

    rsp_t exp_rsp[$];
    int   exp_gnt[$];

    always #5 clk = ~clk;

    logic16_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    function automatic logic [15:0] model(
        input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting for DUT", name);
    endtask

    task automatic set_req(input int i, input logic [1:0] op,
                           input logic [15:0] a, input logic [15:0] b);
        req_op[2*i +: 2] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
        req_valid[i]     = 1'b1;
    endtask

    task automatic expect_op(input int i, input logic [1:0] op,
                             input logic [15:0] a, input logic [15:0] b);
        rsp_t r;
        r.id   = 3'(i);
        r.data = model(op, a, b);
        exp_gnt.push_back(i);
        exp_rsp.push_back(r);
    endtask

    task automatic issue(input int i, input logic [1:0] op,
                         input logic [15:0] a, input logic [15:0] b);
        set_req(i, op, a, b);
        expect_op(i, op, a, b);
    endtask

    task automatic wait_grant(output logic [N-1:0] m);
        m = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (|req_ready) begin
                m = req_ready;
                break;
            end
        end
        if (m == '0) timeout("wait_grant");
    endtask

    task automatic grant_drop();
        logic [N-1:0] m;
        wait_grant(m);
        @(posedge clk);
        #1;
        req_valid = req_valid & ~m;
    endtask

    task automatic wait_rsp();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout("wait_rsp");
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout("wait_idle");
    endtask

    // Monitor: grants and responses are popped from the scoreboard
    always @(negedge clk) begin
        int           g;
        logic [N-1:0] em;
        rsp_t         r;
        if (!reset) begin
            if (|req_ready) begin
                if (exp_gnt.size() == 0) begin
                    check("unexpected_grant", 32'(req_ready), 32'd0);
                end else begin
                    g  = exp_gnt.pop_front();
                    em = '0;
                    em[g] = 1'b1;
                    check("grant", 32'(req_ready), 32'(em));
                end
            end
            if (busy) check("ready_while_busy", 32'(req_ready), 32'd0);
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    r = exp_rsp.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(r.id));
                    check("rsp_data", 32'(rsp_data), 32'(r.data));
                end
            end
        end
    end

    initial begin
        logic [N-1:0] m;

        reset     = 1'b1;
        req_valid = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset with all requesters asking
        repeat (2) begin
            @(negedge clk);
            check("reset_ready", 32'(req_ready), 32'd0);
        end
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Single OR with two-cycle latency
        @(posedge clk);
        #1;
        issue(0, 2'b01, 16'h00FF, 16'h0F0F);
        grant_drop();
        @(negedge clk);
        check("lat_exec_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_resp_valid", 32'(rsp_valid), 32'd1);
        check("single_or_data", 32'(rsp_data), 32'h0FFF);
        wait_idle();

        // Fresh pointer, all requesters held valid
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 2'b10, 16'(i), 16'hFFFF);
        for (int i = 0; i < N; i++) expect_op(i, 2'b10, 16'(i), 16'hFFFF);
        expect_op(0, 2'b10, 16'h0000, 16'hFFFF);
        repeat (5) wait_grant(m);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();

        // Backpressure holds the response and blocks new grants
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        issue(0, 2'b00, 16'hF0F0, 16'h3C3C);
        grant_drop();
        issue(1, 2'b01, 16'h1234, 16'h0001);
        wait_rsp();
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", 32'(rsp_data), 32'h3030);
            check("bp_id", 32'(rsp_id), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_next_grant", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_idle();

        // Move pointer to 3, then skip/wrap to a lone requester 1
        @(posedge clk);
        #1;
        issue(2, 2'b10, 16'h1111, 16'h0101);
        grant_drop();
        wait_idle();
        @(posedge clk);
        #1;
        issue(1, 2'b11, 16'hAAAA, 16'hFFFF);
        grant_drop();
        wait_idle();
        check("not_last_data", 32'(rsp_data), 32'h5555);
        @(posedge clk);
        #1;
        set_req(0, 2'b00, 16'hFFFF, 16'h00FF);
        set_req(1, 2'b01, 16'h0000, 16'h8001);
        set_req(3, 2'b10, 16'h5A5A, 16'hA5A5);
        expect_op(3, 2'b10, 16'h5A5A, 16'hA5A5);
        expect_op(0, 2'b00, 16'hFFFF, 16'h00FF);
        expect_op(1, 2'b01, 16'h0000, 16'h8001);
        repeat (3) grant_drop();
        wait_idle();

        // Reset while the grant is executing
        @(posedge clk);
        #1;
        set_req(2, 2'b00, 16'hFFFF, 16'h0F0F);
        exp_gnt.push_back(2);
        wait_grant(m);
        @(posedge clk);
        #1;
        req_valid = '0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("mid_reset_valid", 32'(rsp_valid), 32'd0);
            check("mid_reset_busy", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        issue(0, 2'b01, 16'h0F00, 16'h00F0);
        issue(3, 2'b10, 16'hFFFF, 16'h0001);
        repeat (2) grant_drop();
        wait_idle();

        check("gnt_queue_empty", 32'(exp_gnt.size()), 32'd0);
        check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
